// File: rtl/cu_vertex_cache_reuse_filter_if.sv
// Command/data bundle of the vertex-line reuse cache.
// master = CU/read-buffer side, slave = the cache itself.
interface cu_vertex_cache_reuse_filter_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 1024,
  parameter int TAG_W  = 8
);
  logic              cmd_in_valid;
  logic              cmd_in_ready;
  logic [ADDR_W-1:0] cmd_in_addr;
  logic [TAG_W-1:0]  cmd_in_tag;
  logic              cmd_in_cacheable;
  logic              cmd_out_valid;
  logic [ADDR_W-1:0] cmd_out_addr;
  logic [TAG_W-1:0]  cmd_out_tag;
  logic              data_in_valid;
  logic [ADDR_W-1:0] data_in_addr;
  logic [TAG_W-1:0]  data_in_tag;
  logic              data_in_cacheable;
  logic [LINE_W-1:0] data_in_line;
  logic              data_out_valid;
  logic [TAG_W-1:0]  data_out_tag;
  logic [LINE_W-1:0] data_out_line;
  logic              data_out_hit;

  modport master (
    output cmd_in_valid, cmd_in_addr,
    output cmd_in_tag, cmd_in_cacheable,
    input  cmd_in_ready,
    input  cmd_out_valid, cmd_out_addr,
    input  cmd_out_tag,
    output data_in_valid, data_in_addr,
    output data_in_tag, data_in_cacheable,
    output data_in_line,
    input  data_out_valid, data_out_tag,
    input  data_out_line, data_out_hit
  );

  modport slave (
    input  cmd_in_valid, cmd_in_addr,
    input  cmd_in_tag, cmd_in_cacheable,
    output cmd_in_ready,
    output cmd_out_valid, cmd_out_addr,
    output cmd_out_tag,
    input  data_in_valid, data_in_addr,
    input  data_in_tag, data_in_cacheable,
    input  data_in_line,
    output data_out_valid, data_out_tag,
    output data_out_line, data_out_hit
  );
endinterface

// File: rtl/cu_vertex_cache_reuse_filter.sv
// Direct-mapped read-only vertex-line cache: hits served locally, misses forwarded.
// Ports: clock, rstn_in, enabled_in, mode_in, bus (slave), hit/miss counters, flush_done.
module cu_vertex_cache_reuse_filter #(
  parameter int ADDR_W         = 64,
  parameter int LINE_W         = 1024,
  parameter int NUM_ENTRIES    = 64,
  parameter int TAG_W          = 8,
  parameter int HIT_FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        rstn_in,
  input  logic        enabled_in,
  input  logic [1:0]  mode_in,
  cu_vertex_cache_reuse_filter_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic        flush_done
);
  localparam int OFF_W = 7;
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CT_W  = ADDR_W - OFF_W - IDX_W;
  localparam int PTR_W = $clog2(HIT_FIFO_DEPTH);
  localparam logic [1:0] M_REUSE = 2'd1;
  localparam logic [1:0] M_FLUSH = 2'd2;
  localparam logic [PTR_W:0] OCC_MAX =
    (PTR_W+1)'(HIT_FIFO_DEPTH - 3);

  typedef enum logic [1:0] {
    S_IDLE, S_ACTIVE, S_FLUSH, S_FWAIT
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              reuse;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } look_t;

  typedef struct packed {
    logic              valid;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } res_t;

  logic rst_n_q;
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) rst_n_q <= 1'b0;
    else          rst_n_q <= 1'b1;
  end

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       fidx_q, fidx_d;
  logic                   flush_done_q, flush_done_d;
  logic                   flush_clr, rdy;
  logic [NUM_ENTRIES-1:0] vld_q, vld_d;
  logic [CT_W-1:0]        ctag_q [NUM_ENTRIES];
  logic [LINE_W-1:0]      cline_q [NUM_ENTRIES];
  look_t                  lk_q, lk_d;
  res_t                   rs_q, rs_d;
  logic [IDX_W-1:0]       look_idx, fill_idx;
  logic [CT_W-1:0]        look_ct;
  logic                   fill_en;
  logic [PTR_W:0]         wptr_q, wptr_d;
  logic [PTR_W:0]         rptr_q, rptr_d, occ;
  logic [TAG_W-1:0]       ftag_q [HIT_FIFO_DEPTH];
  logic [LINE_W-1:0]      fline_q [HIT_FIFO_DEPTH];
  logic                   push, pop;
  logic                   dv_q, dv_d, dh_q, dh_d;
  logic [TAG_W-1:0]       dt_q, dt_d;
  logic [LINE_W-1:0]      dl_q, dl_d;
  logic [31:0]            hit_q, hit_d;
  logic [31:0]            miss_q, miss_d;
  logic                   unused_lsb;

  assign unused_lsb = ^bus.data_in_addr[OFF_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (enabled_in)
          state_d = (mode_in == M_FLUSH) ? S_FLUSH
                                         : S_ACTIVE;
      S_ACTIVE:
        if (!enabled_in)             state_d = S_IDLE;
        else if (mode_in == M_FLUSH) state_d = S_FLUSH;
      S_FLUSH:
        if (!enabled_in)   state_d = S_IDLE;
        else if (&fidx_q)  state_d = S_FWAIT;
      S_FWAIT:
        if (!enabled_in)             state_d = S_IDLE;
        else if (mode_in != M_FLUSH) state_d = S_ACTIVE;
      default: state_d = S_IDLE;
    endcase
  end

  // Two FIFO slots are held back for the lookups already in flight.
  always_comb begin
    rdy          = 1'b0;
    flush_clr    = 1'b0;
    flush_done_d = 1'b0;
    fidx_d       = '0;
    unique case (state_q)
      S_ACTIVE: rdy = (occ <= OCC_MAX);
      S_FLUSH: begin
        flush_clr    = 1'b1;
        fidx_d       = fidx_q + IDX_W'(1);
        flush_done_d = &fidx_q;
      end
      default: ;
    endcase
  end

  assign fill_idx = bus.data_in_addr[OFF_W +: IDX_W];
  assign fill_en  = bus.data_in_valid
                  & bus.data_in_cacheable
                  & (mode_in == M_REUSE)
                  & (state_q != S_FLUSH);

  always_comb begin
    vld_d = vld_q;
    if (flush_clr) vld_d[fidx_q]   = 1'b0;
    if (fill_en)   vld_d[fill_idx] = 1'b1;
  end

  // A fill landing on the looked-up index this cycle forces a miss.
  always_comb begin
    lk_d.valid = bus.cmd_in_valid & rdy;
    lk_d.reuse = bus.cmd_in_cacheable
               & (mode_in == M_REUSE);
    lk_d.addr  = bus.cmd_in_addr;
    lk_d.tag   = bus.cmd_in_tag;
    look_idx   = lk_q.addr[OFF_W +: IDX_W];
    look_ct    = lk_q.addr[ADDR_W-1 -: CT_W];
    rs_d.valid = lk_q.valid;
    rs_d.hit   = lk_q.valid & lk_q.reuse
               & vld_q[look_idx]
               & (ctag_q[look_idx] == look_ct)
               & ~(fill_en & (fill_idx == look_idx));
    rs_d.addr  = lk_q.addr;
    rs_d.tag   = lk_q.tag;
    rs_d.line  = cline_q[look_idx];
  end

  assign occ    = wptr_q - rptr_q;
  assign push   = rs_q.valid & rs_q.hit;
  assign pop    = ~bus.data_in_valid & (occ != '0);
  assign wptr_d = wptr_q + (PTR_W+1)'(push);
  assign rptr_d = rptr_q + (PTR_W+1)'(pop);

  always_comb begin
    dv_d = 1'b0;
    dh_d = 1'b0;
    dt_d = dt_q;
    dl_d = dl_q;
    unique case (1'b1)
      bus.data_in_valid: begin
        dv_d = 1'b1;
        dt_d = bus.data_in_tag;
        dl_d = bus.data_in_line;
      end
      pop: begin
        dv_d = 1'b1;
        dh_d = 1'b1;
        dt_d = ftag_q[rptr_q[PTR_W-1:0]];
        dl_d = fline_q[rptr_q[PTR_W-1:0]];
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (push && !(&hit_q))
      hit_d = hit_q + 32'd1;
    if (rs_q.valid && !rs_q.hit && !(&miss_q))
      miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clock or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q      <= S_IDLE;
      fidx_q       <= '0;
      flush_done_q <= 1'b0;
      vld_q        <= '0;
      lk_q         <= '0;
      rs_q         <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      dv_q         <= 1'b0;
      dh_q         <= 1'b0;
      dt_q         <= '0;
      dl_q         <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      fidx_q       <= fidx_d;
      flush_done_q <= flush_done_d;
      vld_q        <= vld_d;
      lk_q         <= lk_d;
      rs_q         <= rs_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      dv_q         <= dv_d;
      dh_q         <= dh_d;
      dt_q         <= dt_d;
      dl_q         <= dl_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_en) begin
      ctag_q[fill_idx]  <= bus.data_in_addr[ADDR_W-1 -: CT_W];
      cline_q[fill_idx] <= bus.data_in_line;
    end
    if (push) begin
      ftag_q[wptr_q[PTR_W-1:0]]  <= rs_q.tag;
      fline_q[wptr_q[PTR_W-1:0]] <= rs_q.line;
    end
  end

  assign bus.cmd_in_ready   = rdy;
  assign bus.cmd_out_valid  = rs_q.valid & ~rs_q.hit;
  assign bus.cmd_out_addr   = rs_q.addr;
  assign bus.cmd_out_tag    = rs_q.tag;
  assign bus.data_out_valid = dv_q;
  assign bus.data_out_hit   = dh_q;
  assign bus.data_out_tag   = dt_q;
  assign bus.data_out_line  = dl_q;
  assign hit_count          = hit_q;
  assign miss_count         = miss_q;
  assign flush_done         = flush_done_q;
endmodule

// File: tb/tb_cu_vertex_cache_reuse_filter.sv
// Bench for the vertex-line reuse cache: vector table,
// hand sequences and a randomized scoreboard run.
module tb_cu_vertex_cache_reuse_filter;
  localparam int AW = 64;
  localparam int LW = 1024;
  localparam int NE = 64;
  localparam int TW = 8;
  localparam int HD = 8;

  logic        clock = 1'b0;
  logic        rstn_in = 1'b1;
  logic        enabled_in = 1'b0;
  logic [1:0]  mode_in = 2'd1;
  logic [31:0] hit_count, miss_count;
  logic        flush_done;

  cu_vertex_cache_reuse_filter_if #(
    .ADDR_W(AW), .LINE_W(LW), .TAG_W(TW)
  ) bus ();

  cu_vertex_cache_reuse_filter #(
    .ADDR_W(AW), .LINE_W(LW), .NUM_ENTRIES(NE),
    .TAG_W(TW), .HIT_FIFO_DEPTH(HD)
  ) dut (
    .clock(clock),
    .rstn_in(rstn_in),
    .enabled_in(enabled_in),
    .mode_in(mode_in),
    .bus(bus),
    .hit_count(hit_count),
    .miss_count(miss_count),
    .flush_done(flush_done)
  );

  always #5 clock = ~clock;

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    bit          fill;
    logic [63:0] addr;
    logic [7:0]  tag;
    bit          cach;
    logic [1:0]  mode;
    logic [31:0] word;
    bit          fwd;
  } vec_t;

  typedef struct {
    logic [7:0]    tag;
    logic [LW-1:0] line;
  } hexp_t;

  function automatic logic [LW-1:0] rep(input logic [31:0] w);
    return {32{w}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_line(input string nm, input logic [LW-1:0] act,
                          input logic [LW-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h.. want %h..", nm,
                  act[127:0], exp[127:0]);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    bus.cmd_in_valid      = 1'b0;
    bus.cmd_in_addr       = '0;
    bus.cmd_in_tag        = '0;
    bus.cmd_in_cacheable  = 1'b0;
    bus.data_in_valid     = 1'b0;
    bus.data_in_addr      = '0;
    bus.data_in_tag       = '0;
    bus.data_in_cacheable = 1'b0;
    bus.data_in_line      = '0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_rdy"}, bus.cmd_in_ready, 0);
    chk({p, "_cov"}, bus.cmd_out_valid, 0);
    chk({p, "_coa"}, bus.cmd_out_addr, 0);
    chk({p, "_cot"}, bus.cmd_out_tag, 0);
    chk({p, "_dov"}, bus.data_out_valid, 0);
    chk({p, "_doh"}, bus.data_out_hit, 0);
    chk({p, "_dot"}, bus.data_out_tag, 0);
    chk_line({p, "_dol"}, bus.data_out_line, '0);
    chk({p, "_hc"}, hit_count, 0);
    chk({p, "_mc"}, miss_count, 0);
    chk({p, "_fd"}, flush_done, 0);
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.cmd_in_ready) ok = 1;
      else step();
    end
    chk("ready_wait", ok, 1);
  endtask

  task automatic do_fill(input string nm, input logic [63:0] a,
                         input logic [7:0] t, input bit c,
                         input logic [31:0] w);
    bus.data_in_valid     = 1'b1;
    bus.data_in_addr      = a;
    bus.data_in_tag       = t;
    bus.data_in_cacheable = c;
    bus.data_in_line      = rep(w);
    step();
    bus.data_in_valid = 1'b0;
    chk({nm, "_pv"}, bus.data_out_valid, 1);
    chk({nm, "_ph"}, bus.data_out_hit, 0);
    chk({nm, "_pt"}, bus.data_out_tag, t);
    chk_line({nm, "_pl"}, bus.data_out_line, rep(w));
    repeat (2) step();
  endtask

  task automatic run_cmd(input string nm, input logic [63:0] a,
                         input logic [7:0] t, input bit c,
                         input bit fwd, input logic [31:0] w);
    bit seen;
    wait_ready();
    bus.cmd_in_valid     = 1'b1;
    bus.cmd_in_addr      = a;
    bus.cmd_in_tag       = t;
    bus.cmd_in_cacheable = c;
    step();
    bus.cmd_in_valid = 1'b0;
    step();
    chk({nm, "_fwd"}, bus.cmd_out_valid, fwd);
    if (fwd) begin
      chk({nm, "_fa"}, bus.cmd_out_addr, a);
      chk({nm, "_ft"}, bus.cmd_out_tag, t);
    end else begin
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
        step();
        if (bus.data_out_valid && bus.data_out_hit) seen = 1;
      end
      chk({nm, "_hseen"}, seen, 1);
      if (seen) begin
        chk({nm, "_ht"}, bus.data_out_tag, t);
        chk_line({nm, "_hl"}, bus.data_out_line, rep(w));
      end
    end
    repeat (3) step();
  endtask

  task automatic backpressure();
    int sent, got, acc_at_stall;
    bit stalled, hit_in_hold, fwd_seen, held;
    sent = 0; got = 0; acc_at_stall = -1;
    stalled = 0; hit_in_hold = 0; fwd_seen = 0;
    do_fill("bp_fill", 64'h1000, 8'h01, 1, 32'hA5A5A5A5);
    step();
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      held = (cyc < 20);
      bus.data_in_valid     = held;
      bus.data_in_addr      = 64'h0;
      bus.data_in_tag       = 8'hEE;
      bus.data_in_cacheable = 1'b0;
      if (sent < 10 && !bus.cmd_in_ready && !stalled) begin
        stalled = 1;
        acc_at_stall = sent;
      end
      if (sent < 10 && bus.cmd_in_ready) begin
        bus.cmd_in_valid     = 1'b1;
        bus.cmd_in_addr      = 64'h1000;
        bus.cmd_in_tag       = 8'(20 + sent);
        bus.cmd_in_cacheable = 1'b1;
        sent++;
      end else bus.cmd_in_valid = 1'b0;
      step();
      if (bus.cmd_out_valid) fwd_seen = 1;
      if (bus.data_out_valid && bus.data_out_hit) begin
        if (held) hit_in_hold = 1;
        chk("bp_tag", bus.data_out_tag, 8'(20 + got));
        chk_line("bp_line", bus.data_out_line,
                 rep(32'hA5A5A5A5));
        got++;
      end
    end
    clr_in();
    chk("bp_stalled", stalled, 1);
    chk("bp_acc_at_stall", acc_at_stall, HD);
    chk("bp_hit_in_hold", hit_in_hold, 0);
    chk("bp_no_fwd", fwd_seen, 0);
    chk("bp_delivered", got, 10);
    repeat (3) step();
  endtask

  task automatic flush_seq();
    int n;
    bit done, rdy_bad;
    n = 0; done = 0; rdy_bad = 0;
    mode_in = 2'd2;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (bus.cmd_in_ready) rdy_bad = 1;
      if (flush_done) done = 1;
      else n++;
    end
    chk("flush_done_seen", done, 1);
    chk("flush_len", n, NE);
    chk("flush_rdy_low", rdy_bad, 0);
    step();
    chk("flush_pulse_1cyc", flush_done, 0);
    mode_in = 2'd1;
    repeat (2) step();
    run_cmd("post_flush", 64'h1000, 8'h30, 1, 1, 0);
  endtask

  task automatic rand_phase();
    bit            m_v [NE];
    logic [56:0]   m_la [NE];
    logic [LW-1:0] m_ln [NE];
    hexp_t         hq [$];
    hexp_t         h;
    bit            p_v, f_exp, d_exp, dv, dc, cv, nf, hit;
    logic [63:0]   p_a, f_a, da, ca;
    logic [7:0]    p_t, f_t, d_t, dt, ct;
    bit            p_c, cc;
    logic [LW-1:0] d_l, dl;
    int            pi, di, ehit, emiss;
    logic [31:0]   hc0, mc0;
    logic [5:0]    pool [3];
    pool[0] = 6'h20; pool[1] = 6'h21; pool[2] = 6'h05;
    for (int i = 0; i < NE; i++) m_v[i] = 0;
    p_v = 0; f_exp = 0; d_exp = 0;
    p_a = '0; p_t = '0; p_c = 0; f_a = '0; f_t = '0;
    d_t = '0; d_l = '0; ehit = 0; emiss = 0;
    hc0 = hit_count; mc0 = miss_count;
    for (int cyc = 0; cyc < 440; cyc++) begin
      chk("rnd_cmd_v", bus.cmd_out_valid, f_exp);
      if (f_exp) begin
        chk("rnd_cmd_a", bus.cmd_out_addr, f_a);
        chk("rnd_cmd_t", bus.cmd_out_tag, f_t);
      end
      if (d_exp) begin
        chk("rnd_pass_v", bus.data_out_valid, 1);
        chk("rnd_pass_h", bus.data_out_hit, 0);
        chk("rnd_pass_t", bus.data_out_tag, d_t);
        chk_line("rnd_pass_l", bus.data_out_line, d_l);
      end else if (bus.data_out_valid) begin
        chk("rnd_out_is_hit", bus.data_out_hit, 1);
        if (bus.data_out_hit) begin
          chk("rnd_hit_expected", hq.size() > 0, 1);
          if (hq.size() > 0) begin
            h = hq.pop_front();
            chk("rnd_hit_t", bus.data_out_tag, h.tag);
            chk_line("rnd_hit_l", bus.data_out_line, h.line);
          end
        end
      end
      dv = (cyc < 400) && ($urandom_range(0, 99) < 35);
      dc = ($urandom_range(0, 3) != 0);
      da = (64'($urandom_range(0, 2)) << 13)
         | (64'(pool[$urandom_range(0, 2)]) << 7);
      dt = 8'($urandom);
      dl = rep($urandom);
      cv = (cyc < 400) && ($urandom_range(0, 99) < 60)
         && bus.cmd_in_ready;
      cc = ($urandom_range(0, 3) != 0);
      ca = (64'($urandom_range(0, 2)) << 13)
         | (64'(pool[$urandom_range(0, 2)]) << 7);
      ct = 8'($urandom);
      bus.data_in_valid     = dv;
      bus.data_in_addr      = da;
      bus.data_in_tag       = dt;
      bus.data_in_cacheable = dc;
      bus.data_in_line      = dl;
      bus.cmd_in_valid      = cv;
      bus.cmd_in_addr       = ca;
      bus.cmd_in_tag        = ct;
      bus.cmd_in_cacheable  = cc;
      nf = 0;
      di = int'(da[12:7]);
      if (p_v) begin
        pi  = int'(p_a[12:7]);
        hit = p_c && m_v[pi] && (m_la[pi] == p_a[63:7])
            && !(dv && dc && di == pi);
        if (hit) begin
          h.tag = p_t;
          h.line = m_ln[pi];
          hq.push_back(h);
          ehit++;
        end else begin
          nf = 1;
          emiss++;
        end
      end
      if (dv && dc) begin
        m_v[di]  = 1;
        m_la[di] = da[63:7];
        m_ln[di] = dl;
      end
      f_exp = nf; f_a = p_a; f_t = p_t;
      d_exp = dv; d_t = dt; d_l = dl;
      p_v = cv; p_a = ca; p_t = ct; p_c = cc;
      step();
    end
    clr_in();
    chk("rnd_hq_empty", hq.size(), 0);
    chk("rnd_hits", hit_count - hc0, ehit);
    chk("rnd_misses", miss_count - mc0, emiss);
  endtask

  vec_t vt [16];
  int   ehit, emiss;

  initial begin
    clr_in();
    #2 rstn_in = 1'b0;
    repeat (3) step();
    check_zero("rst");
    rstn_in = 1'b1;
    enabled_in = 1'b1;
    mode_in = 2'd1;
    step();

    vt[0]  = '{0, 64'h1000, 8'h03, 1, 2'd1, 32'h0, 1};
    vt[1]  = '{1, 64'h1000, 8'h03, 1, 2'd1, 32'hA5A5A5A5, 0};
    vt[2]  = '{0, 64'h1000, 8'h05, 1, 2'd1, 32'hA5A5A5A5, 0};
    vt[3]  = '{1, 64'h3000, 8'h06, 1, 2'd1, 32'h3C3C3C3C, 0};
    vt[4]  = '{0, 64'h1000, 8'h07, 1, 2'd1, 32'h0, 1};
    vt[5]  = '{0, 64'h3000, 8'h08, 1, 2'd1, 32'h3C3C3C3C, 0};
    vt[6]  = '{0, 64'h3000, 8'h09, 0, 2'd1, 32'h0, 1};
    vt[7]  = '{0, 64'h3000, 8'h0A, 1, 2'd0, 32'h0, 1};
    vt[8]  = '{0, 64'h3000, 8'h0B, 1, 2'd0, 32'h0, 1};
    vt[9]  = '{0, 64'h3000, 8'h0C, 1, 2'd0, 32'h0, 1};
    vt[10] = '{0, 64'h3000, 8'h0D, 1, 2'd0, 32'h0, 1};
    vt[11] = '{1, 64'h5000, 8'h11, 1, 2'd0, 32'h5A5A5A5A, 0};
    vt[12] = '{0, 64'h5000, 8'h12, 1, 2'd1, 32'h0, 1};
    vt[13] = '{0, 64'h3000, 8'h13, 1, 2'd1, 32'h3C3C3C3C, 0};
    vt[14] = '{1, 64'h2000, 8'h14, 0, 2'd1, 32'h77777777, 0};
    vt[15] = '{0, 64'h2000, 8'h15, 1, 2'd1, 32'h0, 1};

    ehit = 0; emiss = 0;
    foreach (vt[i]) begin
      mode_in = vt[i].mode;
      if (vt[i].fill)
        do_fill($sformatf("v%0d", i), vt[i].addr,
                vt[i].tag, vt[i].cach, vt[i].word);
      else begin
        run_cmd($sformatf("v%0d", i), vt[i].addr,
                vt[i].tag, vt[i].cach, vt[i].fwd,
                vt[i].word);
        if (vt[i].fwd) emiss++;
        else ehit++;
      end
    end
    mode_in = 2'd1;
    chk("tbl_hit_count", hit_count, ehit);
    chk("tbl_miss_count", miss_count, emiss);

    backpressure();
    flush_seq();
    rand_phase();
    repeat (3) step();

    bus.cmd_in_valid      = 1'b1;
    bus.cmd_in_addr       = 64'h1000;
    bus.cmd_in_cacheable  = 1'b1;
    bus.data_in_valid     = 1'b1;
    bus.data_in_addr      = 64'h1000;
    bus.data_in_cacheable = 1'b1;
    bus.data_in_line      = rep(32'h12345678);
    repeat (2) step();
    #2 rstn_in = 1'b0;
    #1 check_zero("rst_mid");
    clr_in();
    repeat (3) step();
    rstn_in = 1'b1;
    step();
    run_cmd("post_rst", 64'h1000, 8'h42, 1, 1, 32'h0);
    chk("post_rst_miss", miss_count, 1);
    chk("post_rst_hit", hit_count, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
